// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared types and constants for the camera stream reader.
//                Holds the capture state encoding, default bus/counter widths
//                and the pixel-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_VBLANK = 2'd2,
        ST_ACTIVE = 2'd3
    } cam_state_t;

    localparam int c_default_data_w = 8;
    localparam int c_default_cnt_w  = 12;

    function automatic int cam_pix_w(input int data_w, input int bytes_per_pix);
        return data_w * bytes_per_pix;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : cam_byte_packer
//  Description : Steers successive sensor bus words into the lanes of one
//                pixel. Presents the completed pixel combinationally in the
//                cycle its last word is on the bus, and discards a partial
//                pixel when the line ends early.
//  Ports       : pclk      - pixel clock
//                rst       - synchronous active-high reset
//                clear     - force the word index back to lane 0
//                en        - capture din this cycle
//                line_end  - the current line has ended
//                din       - sensor bus word
//                pix_done  - the word on din completes a pixel
//                pix_data  - completed pixel (valid with pix_done)
//                partial   - pulse: line ended with a pixel half-assembled
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_byte_packer
    import cam_pkg::*;
#(
    parameter int DATA_W        = c_default_data_w,
    parameter int BYTES_PER_PIX = 2,
    parameter bit LSB_FIRST     = 1'b1,
    localparam int PIX_W        = cam_pix_w(DATA_W, BYTES_PER_PIX)
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic              line_end,
    input  logic [DATA_W-1:0] din,
    output logic              pix_done,
    output logic [PIX_W-1:0]  pix_data,
    output logic              partial
);

    localparam int c_idx_w = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(BYTES_PER_PIX - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    logic [c_idx_w-1:0] r_byte_idx;
    logic [c_idx_w-1:0] w_lane;

    // MS-first ordering simply mirrors the lane index.
    assign w_lane   = LSB_FIRST ? r_byte_idx : (c_last_idx - r_byte_idx);
    assign pix_done = en && (r_byte_idx == c_last_idx);
    assign partial  = line_end && (r_byte_idx != '0);

    always_ff @(posedge pclk) begin
        if (rst || clear || line_end) begin
            r_byte_idx <= '0;
        end else if (en) begin
            r_byte_idx <= (r_byte_idx == c_last_idx) ? '0 : r_byte_idx + c_idx_one;
        end
    end

    // The lane being written this cycle is bypassed straight from din so the
    // full pixel is available in the same cycle as its last word.
    for (genvar k = 0; k < BYTES_PER_PIX; k++) begin : g_lane
        localparam logic [c_idx_w-1:0] c_lane = c_idx_w'(k);
        logic              w_hit;
        logic [DATA_W-1:0] r_lane;

        assign w_hit = en && (w_lane == c_lane);
        assign pix_data[k*DATA_W +: DATA_W] = w_hit ? din : r_lane;

        always_ff @(posedge pclk) begin
            if (rst) begin
                r_lane <= '0;
            end else if (w_hit) begin
                r_lane <= din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cam_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : cam_stream_reader
//  Description : DVP/OV-style camera capture. Packs BYTES_PER_PIX bus words
//                into one pixel, tags it with x/y and start-of-frame/line,
//                and gives frame-aligned start/stop plus geometry/error
//                status. Optional crop window when CAM_STREAM_READER_CROP_EN
//                is defined (adds crop_x0/crop_y0/crop_w/crop_h inputs).
//  Ports       : pclk, rst           - clock, synchronous active-high reset
//                din, vsync, href    - sensor bus
//                start, stop         - capture control pulses
//                pixel_valid, pixel, pixel_x, pixel_y, sof, sol - pixel out
//                busy                - capture state is not idle
//                line_width, frame_lines, frame_count - last geometry
//                err_partial         - sticky: a line ended mid-pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_stream_reader
    import cam_pkg::*;
#(
    parameter int DATA_W        = c_default_data_w,
    parameter int BYTES_PER_PIX = 2,
    parameter bit LSB_FIRST     = 1'b1,
    parameter int CNT_W         = c_default_cnt_w,
    localparam int PIX_W        = cam_pix_w(DATA_W, BYTES_PER_PIX)
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              vsync,
    input  logic              href,
    input  logic              start,
    input  logic              stop,
`ifdef CAM_STREAM_READER_CROP_EN
    input  logic [CNT_W-1:0]  crop_x0,
    input  logic [CNT_W-1:0]  crop_y0,
    input  logic [CNT_W-1:0]  crop_w,
    input  logic [CNT_W-1:0]  crop_h,
`endif
    output logic              pixel_valid,
    output logic [PIX_W-1:0]  pixel,
    output logic [CNT_W-1:0]  pixel_x,
    output logic [CNT_W-1:0]  pixel_y,
    output logic              sof,
    output logic              sol,
    output logic              busy,
    output logic [CNT_W-1:0]  line_width,
    output logic [CNT_W-1:0]  frame_lines,
    output logic [CNT_W-1:0]  frame_count,
    output logic              err_partial
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    cam_state_t       r_state;
    cam_state_t       w_state_next;
    logic             r_stop_pend;
    logic             r_href_d;
    logic             r_first_pix;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;

    logic             w_active;
    logic             w_pack_en;
    logic             w_line_end;
    logic             w_frame_end;
    logic             w_start_ok;
    logic             w_enter_active;
    logic             w_line_has_pix;
    logic [CNT_W-1:0] w_y_next;
    logic             w_pix_done;
    logic [PIX_W-1:0] w_pix_data;
    logic             w_partial;
    logic [CNT_W-1:0] w_rel_x;
    logic [CNT_W-1:0] w_rel_y;
    logic             w_in_win;
    logic             w_emit;
    logic             w_sol;
    logic             w_sof;

    assign w_active       = (r_state == ST_ACTIVE);
    assign w_pack_en      = w_active && href && !vsync;
    // A vsync rise with href still high closes the line as if href fell.
    assign w_line_end     = w_active && r_href_d && (!href || vsync);
    assign w_frame_end    = w_active && vsync;
    assign w_start_ok     = (r_state == ST_IDLE) && start && !stop;
    assign w_enter_active = (r_state == ST_VBLANK) && !vsync;
    assign w_line_has_pix = (r_x != '0);
    assign w_y_next       = (w_line_end && w_line_has_pix) ? r_y + c_cnt_one : r_y;
    assign busy           = (r_state != ST_IDLE);

    cam_byte_packer #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX),
        .LSB_FIRST     (LSB_FIRST)
    ) u_packer (
        .pclk     (pclk),
        .rst      (rst),
        .clear    (!w_active),
        .en       (w_pack_en),
        .line_end (w_line_end),
        .din      (din),
        .pix_done (w_pix_done),
        .pix_data (w_pix_data),
        .partial  (w_partial)
    );

`ifdef CAM_STREAM_READER_CROP_EN
    // Range tests use the wrapped differences so x0+w never overflows.
    assign w_rel_x  = r_x - crop_x0;
    assign w_rel_y  = r_y - crop_y0;
    assign w_in_win = (r_x >= crop_x0) && (w_rel_x < crop_w) &&
                      (r_y >= crop_y0) && (w_rel_y < crop_h);
`else
    assign w_rel_x  = r_x;
    assign w_rel_y  = r_y;
    assign w_in_win = 1'b1;
`endif

    assign w_emit = w_pix_done && w_in_win;
    // The first emitted pixel of a line is always at window column 0.
    assign w_sol  = (w_rel_x == '0);
    assign w_sof  = w_sol && r_first_pix;

    // ------------------------------------------------------------------
    // Capture state machine
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (stop)       w_state_next = ST_IDLE;
                else if (vsync) w_state_next = ST_VBLANK;
            end
            ST_VBLANK: begin
                if (!vsync)     w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (vsync)      w_state_next = (r_stop_pend || stop) ? ST_IDLE : ST_VBLANK;
            end
            default:            w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_stop_pend <= 1'b0;
        end else if (w_state_next == ST_IDLE) begin
            r_stop_pend <= 1'b0;
        end else if (stop && ((r_state == ST_VBLANK) || (r_state == ST_ACTIVE))) begin
            r_stop_pend <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_href_d    <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_first_pix <= 1'b0;
        end else begin
            r_href_d <= href;
            if (w_enter_active) begin
                r_x         <= '0;
                r_y         <= '0;
                r_first_pix <= 1'b1;
            end else begin
                if (w_pix_done && (r_x != c_cnt_max)) begin
                    r_x <= r_x + c_cnt_one;
                end
                if (w_line_end && w_line_has_pix) begin
                    r_x <= '0;
                end
                r_y <= w_y_next;
                if (w_emit && w_sof) begin
                    r_first_pix <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered pixel and status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            pixel_valid <= 1'b0;
            pixel       <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            sof         <= 1'b0;
            sol         <= 1'b0;
            line_width  <= '0;
            frame_lines <= '0;
            frame_count <= '0;
            err_partial <= 1'b0;
        end else begin
            pixel_valid <= w_emit;
            sof         <= w_emit && w_sof;
            sol         <= w_emit && w_sol;
            if (w_emit) begin
                pixel   <= w_pix_data;
                pixel_x <= w_rel_x;
                pixel_y <= w_rel_y;
            end
            if (w_line_end && w_line_has_pix) begin
                line_width <= r_x;
            end
            if (w_frame_end) begin
                frame_lines <= w_y_next;
                frame_count <= frame_count + c_cnt_one;
            end
            if (w_start_ok) begin
                err_partial <= 1'b0;
            end else if (w_partial) begin
                err_partial <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_stream_reader
//  Description : Self-checking bench for cam_stream_reader. Two instances
//                (LS-lane-first and MS-lane-first) share one stimulus; the
//                expected pixel stream is queued as stimulus is issued and a
//                monitor compares each strobe against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_stream_reader;

    logic        pclk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        vsync, href, start, stop;

    logic        pv_l, pv_m, sof_l, sof_m, sol_l, sol_m, busy_l, busy_m, err_l, err_m;
    logic [15:0] pix_l, pix_m;
    logic [11:0] px_l, px_m, py_l, py_m;
    logic [11:0] lw_l, lw_m, fl_l, fl_m, fc_l, fc_m;

`ifdef CAM_STREAM_READER_CROP_EN
    logic [11:0] crop_x0 = 12'd0;
    logic [11:0] crop_y0 = 12'd0;
    logic [11:0] crop_w  = 12'hFFF;
    logic [11:0] crop_h  = 12'hFFF;
`endif

    always #5 pclk = ~pclk;

    cam_stream_reader u_lsb (
        .pclk (pclk), .rst (rst), .din (din), .vsync (vsync), .href (href),
        .start (start), .stop (stop),
`ifdef CAM_STREAM_READER_CROP_EN
        .crop_x0 (crop_x0), .crop_y0 (crop_y0), .crop_w (crop_w), .crop_h (crop_h),
`endif
        .pixel_valid (pv_l), .pixel (pix_l), .pixel_x (px_l), .pixel_y (py_l),
        .sof (sof_l), .sol (sol_l), .busy (busy_l), .line_width (lw_l),
        .frame_lines (fl_l), .frame_count (fc_l), .err_partial (err_l)
    );

    cam_stream_reader #(.LSB_FIRST (1'b0)) u_msb (
        .pclk (pclk), .rst (rst), .din (din), .vsync (vsync), .href (href),
        .start (start), .stop (stop),
`ifdef CAM_STREAM_READER_CROP_EN
        .crop_x0 (crop_x0), .crop_y0 (crop_y0), .crop_w (crop_w), .crop_h (crop_h),
`endif
        .pixel_valid (pv_m), .pixel (pix_m), .pixel_x (px_m), .pixel_y (py_m),
        .sof (sof_m), .sol (sol_m), .busy (busy_m), .line_width (lw_m),
        .frame_lines (fl_m), .frame_count (fc_m), .err_partial (err_m)
    );

    typedef struct {
        logic [15:0] pl;
        logic [15:0] pm;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
        logic        sol;
        longint      cyc;
    } exp_t;

    exp_t   q[$];
    int     n_chk = 0;
    int     n_err = 0;
    longint cyc   = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected pixel: lane values for both instances, coordinates, flags and
    // the cycle count at which the strobe must be visible.
    task automatic push(input logic [15:0] pl, input logic [15:0] pm, input int x,
                        input int y, input bit f_sof, input bit f_sol, input longint c);
        exp_t e;
        e.pl = pl; e.pm = pm; e.x = 12'(x); e.y = 12'(y);
        e.sof = f_sof; e.sol = f_sol; e.cyc = c;
        q.push_back(e);
    endtask

    // Scoreboard monitor
    always @(negedge pclk) begin
        if (!rst && (pv_l || pv_m)) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_pixel: got valid lsb=%0b msb=%0b pix=0x%0h, expected no pixel (cycle %0d)",
                         pv_l, pv_m, pix_l, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("valid_lsb", pv_l, 1);
                chk("valid_msb", pv_m, 1);
                chk("pixel_lsb", pix_l, e.pl);
                chk("pixel_msb", pix_m, e.pm);
                chk("pixel_x", px_l, e.x);
                chk("pixel_y", py_l, e.y);
                chk("sof", sof_l, e.sof);
                chk("sol", sol_l, e.sol);
                chk("sof_sol_msb", {sof_m, sol_m}, {e.sof, e.sol});
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic step(input logic h, input logic v, input logic [7:0] d);
        href = h; vsync = v; din = d;
        @(negedge pclk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vs_high(input int n);
        repeat (n) step(1'b0, 1'b1, 8'h00);
    endtask

    // Words are taken from w starting at the least significant byte; the
    // line is closed by two href-low cycles.
    task automatic send_words(input int n, input logic [63:0] w);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, w[8*i +: 8]);
        idle(2);
    endtask

    longint base;

    initial begin
        rst = 1'b1; din = '0; vsync = 1'b0; href = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge pclk);

        // Reset state
        chk("rst_pixel_valid", pv_l, 0);
        chk("rst_pixel", pix_l, 0);
        chk("rst_pixel_xy", {px_l, py_l}, 0);
        chk("rst_sof_sol", {sof_l, sol_l}, 0);
        chk("rst_busy", {busy_l, busy_m}, 0);
        chk("rst_line_width", lw_l, 0);
        chk("rst_frame_lines", fl_l, 0);
        chk("rst_frame_count", fc_l, 0);
        chk("rst_err_partial", err_l, 0);

        rst = 1'b0;
        idle(2);
        chk("idle_busy", busy_l, 0);

        start = 1'b1; step(1'b0, 1'b0, 8'h00); start = 1'b0;
        chk("armed_busy", busy_l, 1);

        // Frame 1: one 4-word line A0 B1 C2 D3
        vs_high(2); idle(2);
        base = cyc;
        push(16'hB1A0, 16'hA0B1, 0, 0, 1, 1, base + 2);
        push(16'hD3C2, 16'hC2D3, 1, 0, 0, 0, base + 4);
        send_words(4, 64'hD3C2B1A0);
        chk("f1_line_width", lw_l, 2);
        vs_high(1);
        chk("f1_frame_lines", fl_l, 1);
        chk("f1_frame_count", fc_l, 1);
        vs_high(1); idle(2);

        // Frame 2: odd-length line, then a 2-word line starting at lane 0
        base = cyc;
        push(16'h2211, 16'h1122, 0, 0, 1, 1, base + 2);
        send_words(3, 64'h332211);
        chk("odd_err_partial", err_l, 1);
        chk("odd_err_partial_msb", err_m, 1);
        chk("odd_line_width", lw_l, 1);
        base = cyc;
        push(16'h5544, 16'h4455, 0, 1, 0, 1, base + 2);
        send_words(2, 64'h5544);
        vs_high(1);
        chk("f2_frame_lines", fl_l, 2);
        chk("f2_frame_count", fc_l, 2);
        vs_high(1); idle(2);

        // Frame 3: 3 lines of 640 pixels, word i carries i[7:0]
        for (int l = 0; l < 3; l++) begin
            base = cyc;
            for (int k = 0; k < 640; k++) begin
                logic [7:0] b0, b1;
                b0 = 8'(2 * k);
                b1 = 8'(2 * k + 1);
                push({b1, b0}, {b0, b1}, k, l, (l == 0) && (k == 0), k == 0, base + 2 * k + 2);
            end
            for (int i = 0; i < 1280; i++) step(1'b1, 1'b0, 8'(i));
            idle(2);
        end
        vs_high(1);
        chk("f3_frame_lines", fl_l, 3);
        chk("f3_line_width", lw_l, 640);
        chk("f3_frame_count", fc_l, 3);
        vs_high(1); idle(2);

        // Frame 4: stop pulsed during the first line; frame still completes
        base = cyc;
        push(16'hE1E0, 16'hE0E1, 0, 0, 1, 1, base + 2);
        push(16'hE3E2, 16'hE2E3, 1, 0, 0, 0, base + 4);
        step(1'b1, 1'b0, 8'hE0);
        stop = 1'b1; step(1'b1, 1'b0, 8'hE1); stop = 1'b0;
        step(1'b1, 1'b0, 8'hE2);
        step(1'b1, 1'b0, 8'hE3);
        idle(2);
        href = 1'b0; vsync = 1'b1; din = 8'h00;
        chk("stop_busy_before_vsync", busy_l, 1);
        @(negedge pclk);
        chk("stop_busy_after_vsync", {busy_l, busy_m}, 0);
        chk("f4_frame_count", fc_l, 4);
        vs_high(1); idle(2);
        send_words(4, 64'h77665544);
        chk("stopped_busy", busy_l, 0);
        chk("stopped_frame_count", fc_l, 4);

        // Frame 5: start while a frame is already streaming
        step(1'b1, 1'b0, 8'h55); step(1'b1, 1'b0, 8'h56); idle(1);
        start = 1'b1; step(1'b1, 1'b0, 8'h66); start = 1'b0;
        step(1'b1, 1'b0, 8'h67); step(1'b1, 1'b0, 8'h68); idle(2);
        chk("rearm_busy", busy_l, 1);
        chk("rearm_err_cleared", {err_l, err_m}, 0);
        send_words(4, 64'h0C0B0A09);
        vs_high(2); idle(2);
        base = cyc;
        push(16'hB1A0, 16'hA0B1, 0, 0, 1, 1, base + 2);
        push(16'hD3C2, 16'hC2D3, 1, 0, 0, 0, base + 4);
        send_words(4, 64'hD3C2B1A0);
        vs_high(1);
        chk("f5_frame_count", fc_l, 5);
        chk("f5_frame_lines", fl_l, 1);
        vs_high(1); idle(4);

        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
